// File: rtl/jk_sched_pkg.sv
// Shared types for the JK bank scheduler: command opcodes, FSM states and
// the rule that gives the q value a JK cell should hold after a command.
// Latency: n/a (types and a pure function). Backpressure: n/a.
package jk_sched_pkg;

   typedef enum logic [1:0] {
      OP_HOLD = 2'b00,
      OP_CLR  = 2'b01,
      OP_SET  = 2'b10,
      OP_TOG  = 2'b11
   } jk_op_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      DRIVE = 2'b01,
      CHECK = 2'b10,
      RESP  = 2'b11
   } state_e;

   // q of a JK cell after one clock with j/k taken from op, starting at q.
   function automatic logic jk_next(input jk_op_e op, input logic q);
      logic r;
      r = q;
      case (op)
         OP_HOLD: r = q;
         OP_CLR:  r = 1'b0;
         OP_SET:  r = 1'b1;
         OP_TOG:  r = ~q;
         default: r = q;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/jk_bank_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first set req bit at or after ptr, wrapping.
// Latency: purely combinational. Backpressure: none; caller decides when to
// use the grant. Ports: req/ptr in, one-hot gnt and its index gnt_id out.
module rr_arbiter #(
   parameter int N    = 4,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id
);

   always_comb begin
      int  c;
      logic found;
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      c      = 0;
      for (int o = 0; o < N; o++) begin
         c = int'(ptr) + o;
         if (c >= N) c = c - N;
         if (!found && req[c]) begin
            found  = 1'b1;
            gnt[c] = 1'b1;
            gnt_id = ID_W'(c);
         end
      end
   end

endmodule

// File: rtl/jk_bank_sched.sv
// Shares one bank of WIDTH JK cells between N_REQ requesters (RR arbitrated).
// Latency: handshake at edge E, rsp_valid from the cycle after edge E+2.
// Backpressure: rsp held until rsp_ready; no new grant until response taken.
// Ports: req_valid/req_op/req_idx/req_ready (requests), rsp_* (response),
// busy, jk_j/jk_k/jk_q (bank). Optional macro JK_BANK_SCHED_CHECK_EN adds a
// readback comparator into rsp_err and the chk_fail_cnt output.
module jk_bank_sched
   import jk_sched_pkg::*;
#(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 8,
   localparam int IDX_W = $clog2(WIDTH),
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [2*N_REQ-1:0]     req_op,
   input  logic [IDX_W*N_REQ-1:0] req_idx,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_q,
   output logic                   rsp_err,
   output logic                   busy,
   output logic [WIDTH-1:0]       jk_j,
   output logic [WIDTH-1:0]       jk_k,
   input  logic [WIDTH-1:0]       jk_q
`ifdef JK_BANK_SCHED_CHECK_EN
   ,
   output logic [7:0]             chk_fail_cnt
`endif
);

   // q padded to a power of two so any idx value reads a defined bit;
   // bad indices read from the zero padding and are masked anyway.
   localparam int PAD_W = 1 << IDX_W;

   state_e           state_q, state_d;
   logic [ID_W-1:0]  ptr_q, ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   jk_op_e           op_q, op_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             bad_q, bad_d;
   logic             rq_q, rq_d;
   logic             err_q, err_d;

   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_id;
   logic [IDX_W-1:0] sel_idx;
   logic [1:0]       sel_op;
   logic [1:0]       op_raw;
   logic [PAD_W-1:0] q_pad;
   logic             cell_q;
   logic             chk_mis;

   rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
      .req    (req_valid),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign sel_idx = req_idx[gnt_id*IDX_W +: IDX_W];
   assign sel_op  = req_op[gnt_id*2 +: 2];
   assign op_raw  = op_q;
   assign q_pad   = PAD_W'(jk_q);
   assign cell_q  = q_pad[idx_q];

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      idx_d   = idx_q;
      bad_d   = bad_q;
      rq_d    = rq_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (|gnt) begin
               id_d    = gnt_id;
               op_d    = jk_op_e'(sel_op);
               idx_d   = sel_idx;
               // Range check done once here; DRIVE and CHECK just use the flag.
               bad_d   = (32'(sel_idx) >= WIDTH);
               ptr_d   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
               state_d = DRIVE;
            end
         end
         DRIVE: state_d = CHECK;
         CHECK: begin
            rq_d    = bad_q ? 1'b0 : cell_q;
            err_d   = bad_q | chk_mis;
            state_d = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         op_q    <= OP_HOLD;
         idx_q   <= '0;
         bad_q   <= 1'b0;
         rq_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         bad_q   <= bad_d;
         rq_q    <= rq_d;
         err_q   <= err_d;
      end
   end

   // Only the target cell sees j/k, and only for the single DRIVE cycle.
   always_comb begin
      jk_j = '0;
      jk_k = '0;
      if (state_q == DRIVE && !bad_q) begin
         jk_j[idx_q] = op_raw[1];
         jk_k[idx_q] = op_raw[0];
      end
   end

`ifdef JK_BANK_SCHED_CHECK_EN
   logic       qprev_q, qprev_d;
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      qprev_d = qprev_q;
      if (state_q == IDLE && |gnt) qprev_d = q_pad[sel_idx];
   end

   assign chk_mis = (state_q == CHECK) && !bad_q && (cell_q != jk_next(op_q, qprev_q));

   always_comb begin
      cnt_d = cnt_q;
      if (chk_mis && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         qprev_q <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         qprev_q <= qprev_d;
         cnt_q   <= cnt_d;
      end
   end

   assign chk_fail_cnt = cnt_q;
`else
   assign chk_mis = 1'b0;
`endif

   assign req_ready = (state_q == IDLE) ? gnt : '0;
   assign rsp_valid = (state_q == RESP);
   assign rsp_id    = id_q;
   assign rsp_q     = rq_q;
   assign rsp_err   = err_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_jk_bank_sched.sv
// Bench for jk_bank_sched: directed steps plus random traffic against a
// queue-free reference (RR pointer and cell values kept as plain variables).
// A second instance with WIDTH=6 exercises out-of-range cell indices.
module tb_jk_bank_sched;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // Instance A: N_REQ=4, WIDTH=8
   logic [3:0]  req_valid, req_ready;
   logic [7:0]  req_op;
   logic [11:0] req_idx;
   logic        rsp_valid, rsp_ready, rsp_q, rsp_err, busy;
   logic [1:0]  rsp_id;
   logic [7:0]  jk_j, jk_k, jk_q;
   logic [7:0]  bank  = '0;
   logic [7:0]  stuck = '0;
`ifdef JK_BANK_SCHED_CHECK_EN
   logic [7:0]  chk_fail_cnt, chk_fail_cnt_b;
`endif

   // Instance B: N_REQ=2, WIDTH=6
   logic [1:0]  req_valid_b, req_ready_b;
   logic [3:0]  req_op_b;
   logic [5:0]  req_idx_b;
   logic        rsp_valid_b, rsp_ready_b, rsp_q_b, rsp_err_b, busy_b;
   logic        rsp_id_b;
   logic [5:0]  jk_j_b, jk_k_b, jk_q_b;

   jk_bank_sched #(.N_REQ(4), .WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_op(req_op), .req_idx(req_idx), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_q(rsp_q),
      .rsp_err(rsp_err), .busy(busy), .jk_j(jk_j), .jk_k(jk_k), .jk_q(jk_q)
`ifdef JK_BANK_SCHED_CHECK_EN
      , .chk_fail_cnt(chk_fail_cnt)
`endif
   );

   jk_bank_sched #(.N_REQ(2), .WIDTH(6)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid_b), .req_op(req_op_b), .req_idx(req_idx_b), .req_ready(req_ready_b),
      .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_id(rsp_id_b), .rsp_q(rsp_q_b),
      .rsp_err(rsp_err_b), .busy(busy_b), .jk_j(jk_j_b), .jk_k(jk_k_b), .jk_q(jk_q_b)
`ifdef JK_BANK_SCHED_CHECK_EN
      , .chk_fail_cnt(chk_fail_cnt_b)
`endif
   );

   // Physical JK bank for instance A; stuck bits force q low at the output.
   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         case ({jk_j[i], jk_k[i]})
            2'b01:   bank[i] <= 1'b0;
            2'b10:   bank[i] <= 1'b1;
            2'b11:   bank[i] <= ~bank[i];
            default: bank[i] <= bank[i];
         endcase
      end
   end
   assign jk_q = bank & ~stuck;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: the RR pointer and the value each cell should hold.
   int         ptr_m = 0;
   logic [7:0] mbank = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One command on instance A, entered and left at a negedge with the DUT idle.
   task automatic run_txn(input logic [3:0] vmask, input logic [7:0] ops,
                          input logic [11:0] idxs, input int rdy_delay, output int gid);
      int         w;
      int         ix;
      logic [1:0] op;
      logic       qexp, qobs, err_exp;
      logic [3:0] gnt_exp;
      logic [7:0] j_exp, k_exp;
      w = -1;
      for (int o = 0; o < 4; o++) begin
         int c;
         c = (ptr_m + o) % 4;
         if (w < 0 && vmask[c]) w = c;
      end
      req_valid = vmask; req_op = ops; req_idx = idxs; rsp_ready = 1'b0;
      #1;
      gnt_exp = 4'b0001 << w;
      chk("grant", 32'(req_ready), 32'(gnt_exp));
      chk("busy_idle", 32'(busy), 0);
      op = ops[2*w +: 2];
      ix = int'(idxs[3*w +: 3]);
      case (op)
         2'b00:   qexp = mbank[ix];
         2'b01:   qexp = 1'b0;
         2'b10:   qexp = 1'b1;
         default: qexp = ~mbank[ix];
      endcase
      mbank[ix] = qexp;
      qobs = qexp & ~stuck[ix];
      err_exp = 1'b0;
`ifdef JK_BANK_SCHED_CHECK_EN
      err_exp = (qobs != qexp);
`endif
      ptr_m = (w + 1) % 4;
      gid = w;
      j_exp = '0; k_exp = '0;
      j_exp[ix] = op[1];
      k_exp[ix] = op[0];
      @(negedge clk);  // DRIVE
      chk("drive_j", 32'(jk_j), 32'(j_exp));
      chk("drive_k", 32'(jk_k), 32'(k_exp));
      chk("drive_rdy", 32'(req_ready), 0);
      chk("drive_busy", 32'(busy), 1);
      @(negedge clk);  // CHECK
      chk("check_j", 32'(jk_j | jk_k), 0);
      chk("check_vld", 32'(rsp_valid), 0);
      @(negedge clk);  // RESP
      chk("rsp_vld", 32'(rsp_valid), 1);
      chk("rsp_id", 32'(rsp_id), 32'(w));
      chk("rsp_q", 32'(rsp_q), 32'(qobs));
      chk("rsp_err", 32'(rsp_err), 32'(err_exp));
      for (int d = 0; d < rdy_delay; d++) begin
         @(negedge clk);
         chk("hold_vld", 32'(rsp_valid), 1);
         chk("hold_id", 32'(rsp_id), 32'(w));
         chk("hold_q", 32'(rsp_q), 32'(qobs));
         chk("hold_rdy", 32'(req_ready), 0);
         chk("hold_busy", 32'(busy), 1);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = '0;
      #1;
      chk("back_idle", 32'(busy), 0);
      chk("rsp_dropped", 32'(rsp_valid), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int rr_exp [5] = '{0, 1, 2, 3, 0};
      logic [3:0] vm;
      logic [7:0] ops;
      logic [11:0] idxs;
      int dly;

      rst_n = 1'b0;
      req_valid = '0; req_op = '0; req_idx = '0; rsp_ready = 1'b0;
      req_valid_b = '0; req_op_b = '0; req_idx_b = '0; rsp_ready_b = 1'b0; jk_q_b = '0;
      @(negedge clk); @(negedge clk);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_vld", 32'(rsp_valid), 0);
      chk("rst_rdy", 32'(req_ready), 0);
      chk("rst_jk", 32'({jk_j, jk_k}), 0);
      chk("rst_rsp", 32'({rsp_id, rsp_q, rsp_err}), 0);
`ifdef JK_BANK_SCHED_CHECK_EN
      chk("rst_cnt", 32'(chk_fail_cnt), 0);
`endif
      rst_n = 1'b1;
      @(negedge clk);

      // Reset while driving a TOG on cell 1: everything drops immediately.
      req_valid = 4'b0001; req_op = 8'h03; req_idx = 12'h001;
      @(negedge clk);
      chk("pre_rst_j", 32'(jk_j), 32'h02);
      req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_jk", 32'({jk_j, jk_k}), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_vld", 32'(rsp_valid), 0);
      chk("mid_rst_rdy", 32'(req_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      @(negedge clk);
      chk("bank_untouched", 32'(jk_q), 0);

      // Single SET on cell 3 from requester 0.
      run_txn(4'b0001, 8'h02, 12'h003, 0, g);
      chk("single_id", 32'(g), 0);

      // Full op table on cell 5: CLR, SET, TOG, TOG, HOLD.
      run_txn(4'b0001, 8'h01, 12'h005, 0, g);
      run_txn(4'b0001, 8'h02, 12'h005, 0, g);
      run_txn(4'b0001, 8'h03, 12'h005, 0, g);
      run_txn(4'b0001, 8'h03, 12'h005, 0, g);
      run_txn(4'b0001, 8'h00, 12'h005, 0, g);
      chk("op_table_cell5", 32'(jk_q[5]), 1);

      // RR fairness from a freshly reset pointer, all requesters always valid.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      for (int t = 0; t < 5; t++) begin
         run_txn(4'b1111, 8'b11_10_01_00, {3'd7, 3'd6, 3'd4, 3'd2}, 0, g);
         chk("rr_order", 32'(g), 32'(rr_exp[t]));
      end

      // Backpressure: response held for 10 cycles, then immediate next grant.
      run_txn(4'b0100, 8'h30, 12'h200, 10, g);
      run_txn(4'b0010, 8'h0C, 12'h008, 0, g);
      chk("after_bp_id", 32'(g), 1);

      // Out-of-range cell on the WIDTH=6 instance.
      req_valid_b = 2'b01; req_op_b = 4'b0010; req_idx_b = 6'd7; jk_q_b = 6'h3F;
      #1;
      chk("b_grant", 32'(req_ready_b), 1);
      @(negedge clk);
      req_valid_b = '0;
      chk("b_bad_jk", 32'({jk_j_b, jk_k_b}), 0);
      @(negedge clk);
      @(negedge clk);
      chk("b_bad_vld", 32'(rsp_valid_b), 1);
      chk("b_bad_err", 32'(rsp_err_b), 1);
      chk("b_bad_q", 32'(rsp_q_b), 0);
      rsp_ready_b = 1'b1;
      @(negedge clk);
      rsp_ready_b = 1'b0;
      // In-range SET on requester 1 (pointer moved past 0).
      req_valid_b = 2'b11; req_op_b = 4'b1010; req_idx_b = {3'd2, 3'd2}; jk_q_b = 6'h04;
      #1;
      chk("b_grant2", 32'(req_ready_b), 2);
      @(negedge clk);
      req_valid_b = '0;
      chk("b_good_j", 32'(jk_j_b), 32'h04);
      @(negedge clk);
      @(negedge clk);
      chk("b_good_err", 32'(rsp_err_b), 0);
      chk("b_good_q", 32'(rsp_q_b), 1);
      chk("b_good_id", 32'(rsp_id_b), 1);
      rsp_ready_b = 1'b1;
      @(negedge clk);
      rsp_ready_b = 1'b0;

`ifdef JK_BANK_SCHED_CHECK_EN
      // Cell 2 stuck at 0: SET reads back 0, flagged and counted once.
      stuck = 8'h04;
      ptr_m = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      run_txn(4'b0001, 8'h02, 12'h002, 0, g);
      chk("stuck_cnt", 32'(chk_fail_cnt), 1);
      stuck = 8'h00;
`endif

      // Random traffic.
      for (int t = 0; t < 24; t++) begin
         vm   = 4'($urandom_range(1, 15));
         ops  = 8'($urandom);
         idxs = 12'($urandom);
         dly  = $urandom_range(0, 3);
         run_txn(vm, ops, idxs, dly, g);
      end
      chk("final_bank", 32'(jk_q), 32'(mbank));
`ifdef JK_BANK_SCHED_CHECK_EN
      chk("final_cnt", 32'(chk_fail_cnt), 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
